writeback_regfile: RTL and testbench

Write-back stage and architectural register file for the 5-stage MIPS pipeline. Consumes the MEM/WB pipeline register outputs and selects write-back data (load data or ALU result). Commits it to the 32×32 register file and serves the two ID-stage read ports with same-cycle write-through bypass. Also exports the selected write-back value for EX-stage forwarding and keeps a committed-write counter for bring-up and debug.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/regfile_bank.sv | 59 +++++
 rtl/writeback_regfile.sv | 94 +++++++++
 tb/tb_writeback_regfile.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants and helpers for the MIPS write-back stage
//               and register file.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned NUM_RPORTS = 3;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Write-back source select: load data when MemtoReg is set, else ALU result.
  function automatic logic [DATA_W-1:0] wb_select(
    input logic              mem_to_reg,
    input logic [DATA_W-1:0] load_data,
    input logic [DATA_W-1:0] alu_result
  );
    return mem_to_reg ? load_data : alu_result;
  endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/regfile_bank.sv
`default_nettype none
// ============================================================================
// Module      : regfile_bank
// Description : 32x32 architectural register storage. One write port, three
//               raw (unbypassed) read ports. Register 0 always reads zero.
// Ports       : clk_i     - clock, rising edge
//               rst_ni    - asynchronous active-low reset, clears storage
//               we_i      - write enable (caller guarantees waddr_i != 0)
//               waddr_i   - write register index
//               wdata_i   - write data
//               raddr_i   - read indices, one per read port
//               rdata_o   - stored value of each indexed register
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_bank
  import mips_pkg::*;
(
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   we_i,
  input  logic [REG_ADDR_W-1:0]                  waddr_i,
  input  logic [DATA_W-1:0]                      wdata_i,
  input  logic [NUM_RPORTS-1:0][REG_ADDR_W-1:0]  raddr_i,
  output logic [NUM_RPORTS-1:0][DATA_W-1:0]      rdata_o
);

  // Only registers 1..31 hold state; register 0 is a constant.
  logic [DATA_W-1:0] regs_q [NUM_REGS-1:1];

  // Full 32-entry view with entry 0 tied low, so reads index it directly.
  logic [DATA_W-1:0] read_view [NUM_REGS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (waddr_i == REG_ADDR_W'(i)) begin
          regs_q[i] <= wdata_i;
        end
      end
    end
  end

  always_comb begin
    read_view[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      read_view[i] = regs_q[i];
    end
  end

  for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rport
    assign rdata_o[p] = read_view[raddr_i[p]];
  end

endmodule : regfile_bank
`default_nettype wire

// File: rtl/writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module      : writeback_regfile
// Description : MIPS write-back stage plus architectural register file.
//               Selects write-back data, commits it, serves the two ID read
//               ports with same-cycle write-through bypass, exports the WB
//               value for EX forwarding, and counts committed writes.
// Ports       : clk                - pipeline clock
//               rst                - asynchronous active-low reset
//               MEMtoWB_*          - MEM/WB pipeline register contents
//               ID_rs / ID_rt      - ID-stage read addresses
//               ID_ReadData1/2     - bypassed read data
//               WB_WriteData       - selected write-back value
//               WB_WriteValid      - write will commit this cycle
//               dbg_addr/dbg_data  - unbypassed debug read port
//               write_count        - committed writes since reset (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_regfile
  import mips_pkg::*;
#(
  parameter int unsigned COUNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     MEMtoWB_ReadData,
  input  logic [DATA_W-1:0]     MEMtoWB_ALU_result,
  input  logic [REG_ADDR_W-1:0] MEMtoWB_RegDest,
  input  logic                  MEMtoWB_MemtoReg,
  input  logic                  MEMtoWB_RegWrite,
  input  logic [REG_ADDR_W-1:0] ID_rs,
  input  logic [REG_ADDR_W-1:0] ID_rt,
  output logic [DATA_W-1:0]     ID_ReadData1,
  output logic [DATA_W-1:0]     ID_ReadData2,
  output logic [DATA_W-1:0]     WB_WriteData,
  output logic                  WB_WriteValid,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]     dbg_data,
  output logic [COUNT_W-1:0]    write_count
);

  logic [NUM_RPORTS-1:0][REG_ADDR_W-1:0] raddr;
  logic [NUM_RPORTS-1:0][DATA_W-1:0]     rdata_raw;
  logic [COUNT_W-1:0]                    count_q;
  logic [COUNT_W-1:0]                    count_d;

  assign WB_WriteData  = wb_select(MEMtoWB_MemtoReg, MEMtoWB_ReadData,
                                   MEMtoWB_ALU_result);
  // Destination 0 is never a real write: no commit, no bypass, no count.
  assign WB_WriteValid = MEMtoWB_RegWrite && (MEMtoWB_RegDest != REG_ZERO);

  assign raddr[0] = ID_rs;
  assign raddr[1] = ID_rt;
  assign raddr[2] = dbg_addr;

  regfile_bank u_bank (
    .clk_i   (clk),
    .rst_ni  (rst),
    .we_i    (WB_WriteValid),
    .waddr_i (MEMtoWB_RegDest),
    .wdata_i (WB_WriteData),
    .raddr_i (raddr),
    .rdata_o (rdata_raw)
  );

  // Write-before-read: an in-flight write is visible to ID the same cycle.
  // Index 0 can never hit because WB_WriteValid excludes destination 0.
  assign ID_ReadData1 = (WB_WriteValid && (ID_rs == MEMtoWB_RegDest)) ?
                        WB_WriteData : rdata_raw[0];
  assign ID_ReadData2 = (WB_WriteValid && (ID_rt == MEMtoWB_RegDest)) ?
                        WB_WriteData : rdata_raw[1];

  // Debug port shows storage only, never the pending write.
  assign dbg_data = rdata_raw[2];

  always_comb begin
    count_d = count_q;
    if (WB_WriteValid) begin
      count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign write_count = count_q;

endmodule : writeback_regfile
`default_nettype wire

// File: tb/tb_writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_regfile
// Description : Self-checking bench for writeback_regfile with a behavioural
//               register-file model and directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_regfile;

  localparam int CW = 4;

  logic        clk;
  logic        rst;
  logic [31:0] rd_data, alu_res;
  logic [4:0]  dest, rs, rt, daddr;
  logic        m2r, regwr;
  logic [31:0] rd1, rd2, wdata, dbgd;
  logic        wvalid;
  logic [CW-1:0] wcount;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  logic [31:0] m_regs [32];
  int          m_count;

  writeback_regfile #(.COUNT_W(CW)) dut (
    .clk                (clk),
    .rst                (rst),
    .MEMtoWB_ReadData   (rd_data),
    .MEMtoWB_ALU_result (alu_res),
    .MEMtoWB_RegDest    (dest),
    .MEMtoWB_MemtoReg   (m2r),
    .MEMtoWB_RegWrite   (regwr),
    .ID_rs              (rs),
    .ID_rt              (rt),
    .ID_ReadData1       (rd1),
    .ID_ReadData2       (rd2),
    .WB_WriteData       (wdata),
    .WB_WriteValid      (wvalid),
    .dbg_addr           (daddr),
    .dbg_data           (dbgd),
    .write_count        (wcount)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a plain array of 32 words and an integer counter.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_count = 0;
    end else if (regwr && dest != 5'd0) begin
      m_regs[dest] = m2r ? rd_data : alu_res;
      m_count      = (m_count + 1) % (1 << CW);
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [31:0] e_wd, e_rd1, e_rd2;
      logic        e_wv;
      e_wd  = m2r ? rd_data : alu_res;
      e_wv  = regwr && (dest != 5'd0);
      e_rd1 = (e_wv && rs == dest) ? e_wd : m_regs[rs];
      e_rd2 = (e_wv && rt == dest) ? e_wd : m_regs[rt];
      check("cyc_wdata",  wdata, e_wd);
      check("cyc_wvalid", {31'd0, wvalid}, {31'd0, e_wv});
      check("cyc_rd1",    rd1, e_rd1);
      check("cyc_rd2",    rd2, e_rd2);
      check("cyc_dbg",    dbgd, m_regs[daddr]);
      check("cyc_count",  {{(32-CW){1'b0}}, wcount}, 32'(m_count));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic sel, input logic [4:0] d,
                       input logic [31:0] ld, input logic [31:0] alu);
    regwr = we; m2r = sel; dest = d; rd_data = ld; alu_res = alu;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    rs = 5'd0; rt = 5'd0; daddr = 5'd0;
    #1;
    check("reset_count", {{(32-CW){1'b0}}, wcount}, 32'd0);
    check("reset_dbg0", dbgd, 32'd0);
    step(); step();
    rst = 1'b1;
    cmp_en = 1'b1;

    // Load vs ALU select.
    drive(1'b1, 1'b1, 5'd8, 32'hDEADBEEF, 32'h00001234);
    step();
    drive(1'b1, 1'b0, 5'd9, 32'hDEADBEEF, 32'h00001234);
    step();
    drive(1'b0, 1'b0, 5'd9, 32'd0, 32'd0);
    daddr = 5'd8; #1;
    check("load_reg8", dbgd, 32'hDEADBEEF);
    daddr = 5'd9; #1;
    check("alu_reg9", dbgd, 32'h00001234);
    check("count_two", {{(32-CW){1'b0}}, wcount}, 32'd2);

    // Same-cycle bypass on both ports; debug port still shows old value.
    drive(1'b1, 1'b0, 5'd5, 32'd0, 32'hA5A5A5A5);
    rs = 5'd5; rt = 5'd5; daddr = 5'd5; #1;
    check("bypass_rd1", rd1, 32'hA5A5A5A5);
    check("bypass_rd2", rd2, 32'hA5A5A5A5);
    check("bypass_dbg_old", dbgd, 32'd0);
    step();
    drive(1'b0, 1'b0, 5'd5, 32'd0, 32'd0); #1;
    check("bypass_stored", dbgd, 32'hA5A5A5A5);
    check("count_three", {{(32-CW){1'b0}}, wcount}, 32'd3);

    // Register zero write is dropped.
    drive(1'b1, 1'b0, 5'd0, 32'd0, 32'hFFFFFFFF);
    rs = 5'd0; daddr = 5'd0; #1;
    check("zero_rd1", rd1, 32'd0);
    check("zero_valid", {31'd0, wvalid}, 32'd0);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0); #1;
    check("zero_stored", dbgd, 32'd0);
    check("zero_count", {{(32-CW){1'b0}}, wcount}, 32'd3);

    // RegWrite=0 neither bypasses nor stores.
    drive(1'b1, 1'b0, 5'd3, 32'd0, 32'h00000033);
    step();
    drive(1'b0, 1'b1, 5'd3, 32'h77777777, 32'h77777777);
    rs = 5'd3; daddr = 5'd3; #1;
    check("nowr_rd1", rd1, 32'h00000033);
    step(); #1;
    check("nowr_stored", dbgd, 32'h00000033);
    check("nowr_count", {{(32-CW){1'b0}}, wcount}, 32'd4);

    // Randomised traffic, checked every cycle by the compare process.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] d;
      d = 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 3) != 0), 1'($urandom), d, $urandom, $urandom);
      rs    = ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31));
      rt    = ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31));
      daddr = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
      step();
    end

    // Mid-stream reset: the pending write is lost and nothing needs a clock.
    drive(1'b1, 1'b0, 5'd7, 32'd0, 32'h0BADF00D);
    rs = 5'd1; rt = 5'd2;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      daddr = 5'(i);
      #1;
      check("rst_dbg", dbgd, 32'd0);
    end
    check("rst_count", {{(32-CW){1'b0}}, wcount}, 32'd0);
    step();
    drive(1'b0, 1'b0, 5'd7, 32'd0, 32'd0);
    daddr = 5'd7; #1;
    check("rst_lost_write", dbgd, 32'd0);
    check("rst_no_incr", {{(32-CW){1'b0}}, wcount}, 32'd0);
    rst = 1'b1;

    // Counter wrap at 2^CW valid writes.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 5'(1 + (i % 31)), 32'd0, 32'(i));
      step();
      if (i == 14) check("wrap_15", {{(32-CW){1'b0}}, wcount}, 32'd15);
    end
    drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0); #1;
    check("wrap_zero", {{(32-CW){1'b0}}, wcount}, 32'd0);
    step();

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_writeback_regfile
`default_nettype wire
